// File: rtl/step_counter_bank_pkg.sv
// Shared types and constants for the step_counter_bank slice.
// Sticky clip storage is built only when STEP_COUNTER_BANK_CLIP_EN is defined.
package step_counter_bank_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_WRAP = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int unsigned RST_COUNT = 0;

endpackage

// File: rtl/step_counter_lane.sv
// One channel of the bank: bounded up/down counter, terminal flags and clip flag.
// Clip storage exists only when STEP_COUNTER_BANK_CLIP_EN is defined.
module step_counter_lane
  import step_counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DELTA_W = 4
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               up_dn_i,
  input  logic [DELTA_W-1:0] delta_i,
  input  logic               preload_i,
  input  logic [WIDTH-1:0]   pl_data_i,
  input  logic [WIDTH-1:0]   lo_i,
  input  logic [WIDTH-1:0]   hi_i,
  input  logic [1:0]         mode_i,
  input  logic               clip_clr_i,
  input  logic               cfg_bad_i,
  output logic [WIDTH-1:0]   q_o,
  output logic               at_max_o,
  output logic               at_min_o,
  output logic               clip_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             at_max_q, at_min_q;
  logic             clip_set;

  logic [WIDTH:0]   q_x, d_x, lo_x, hi_x, up_t, dn_t, lo_pd, span, wrap_t;
  logic [WIDTH-1:0] clamp_v, sat_v;
  logic             in_rng;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode_i);

  // All bound arithmetic is one bit wider so q+delta and lo+delta never overflow.
  always_comb begin
    q_x    = {1'b0, q_q};
    d_x    = {{(WIDTH + 1 - DELTA_W){1'b0}}, delta_i};
    lo_x   = {1'b0, lo_i};
    hi_x   = {1'b0, hi_i};
    up_t   = q_x + d_x;
    dn_t   = q_x - d_x;
    lo_pd  = lo_x + d_x;
    span   = hi_x - lo_x + (WIDTH + 1)'(1);
    wrap_t = up_dn_i ? (up_t - span) : (q_x + span - d_x);
    in_rng = up_dn_i ? (up_t <= hi_x) : (q_x >= lo_pd);
    sat_v  = up_dn_i ? hi_i : lo_i;

    if (pl_data_i < lo_i)      clamp_v = lo_i;
    else if (pl_data_i > hi_i) clamp_v = hi_i;
    else                       clamp_v = pl_data_i;

    q_d      = q_q;
    clip_set = 1'b0;
    if (!cfg_bad_i) begin
      if (preload_i) begin
        q_d = clamp_v;
      end else if (en_i && (delta_i != '0)) begin
        if (in_rng) begin
          q_d = up_dn_i ? up_t[WIDTH-1:0] : dn_t[WIDTH-1:0];
        end else begin
          clip_set = 1'b1;
          case (mode_s)
            MODE_SAT:  q_d = sat_v;
            MODE_WRAP: q_d = (d_x > span) ? sat_v : wrap_t[WIDTH-1:0];
            default:   q_d = q_q;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      q_q      <= WIDTH'(RST_COUNT);
      at_max_q <= (WIDTH'(RST_COUNT) == hi_i);
      at_min_q <= (WIDTH'(RST_COUNT) == lo_i);
    end else begin
      q_q      <= q_d;
      at_max_q <= (q_d == hi_i);
      at_min_q <= (q_d == lo_i);
    end
  end

  assign q_o      = q_q;
  assign at_max_o = at_max_q;
  assign at_min_o = at_min_q;

`ifdef STEP_COUNTER_BANK_CLIP_EN
  logic clip_q, clip_d;

  // A clip event in the same cycle as a clear leaves the flag set.
  always_comb begin
    clip_d = clip_q;
    if (clip_set)        clip_d = 1'b1;
    else if (clip_clr_i) clip_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_i) clip_q <= 1'b0;
    else          clip_q <= clip_d;
  end

  assign clip_o = clip_q;
`else
  logic unused_clip;
  assign unused_clip = clip_set ^ clip_clr_i;
  assign clip_o      = 1'b0;
`endif

endmodule

// File: rtl/step_counter_bank.sv
// Bank of N_CH bounded step counters sharing step size, preload value and [lo,hi].
// Optional sticky clip flags controlled by STEP_COUNTER_BANK_CLIP_EN.
module step_counter_bank
  import step_counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DELTA_W = 4,
  parameter int unsigned N_CH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       up_dn,
  input  logic [DELTA_W-1:0]    delta,
  input  logic [N_CH-1:0]       preload,
  input  logic [WIDTH-1:0]      pl_data,
  input  logic [WIDTH-1:0]      lo,
  input  logic [WIDTH-1:0]      hi,
  input  logic [1:0]            mode,
  input  logic [N_CH-1:0]       clip_clr,
  output logic [N_CH*WIDTH-1:0] qout,
  output logic [N_CH-1:0]       at_max,
  output logic [N_CH-1:0]       at_min,
  output logic [N_CH-1:0]       clip,
  output logic                  cfg_err
);

  logic cfg_bad;
  logic cfg_err_q;

  // Evaluated on the live bounds so a bad window blocks updates in the same cycle.
  assign cfg_bad = (hi < lo);

  always_ff @(posedge clk) begin
    if (!reset) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_bad;
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    step_counter_lane #(
      .WIDTH   (WIDTH),
      .DELTA_W (DELTA_W)
    ) u_lane (
      .clk        (clk),
      .reset_i    (reset),
      .en_i       (en[g]),
      .up_dn_i    (up_dn[g]),
      .delta_i    (delta),
      .preload_i  (preload[g]),
      .pl_data_i  (pl_data),
      .lo_i       (lo),
      .hi_i       (hi),
      .mode_i     (mode),
      .clip_clr_i (clip_clr[g]),
      .cfg_bad_i  (cfg_bad),
      .q_o        (qout[g*WIDTH +: WIDTH]),
      .at_max_o   (at_max[g]),
      .at_min_o   (at_min[g]),
      .clip_o     (clip[g])
    );
  end

endmodule

// File: tb/tb_step_counter_bank.sv
// Directed self-checking bench for step_counter_bank (WIDTH=8, DELTA_W=4, N_CH=4).
// Clip expectations follow STEP_COUNTER_BANK_CLIP_EN.
module tb_step_counter_bank;

`ifdef STEP_COUNTER_BANK_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  en, up_dn, preload, clip_clr;
  logic [3:0]  delta;
  logic [7:0]  pl_data, lo, hi;
  logic [1:0]  mode;
  logic [31:0] qout;
  logic [3:0]  at_max, at_min, clip;
  logic        cfg_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  step_counter_bank #(
    .WIDTH   (8),
    .DELTA_W (4),
    .N_CH    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .delta    (delta),
    .preload  (preload),
    .pl_data  (pl_data),
    .lo       (lo),
    .hi       (hi),
    .mode     (mode),
    .clip_clr (clip_clr),
    .qout     (qout),
    .at_max   (at_max),
    .at_min   (at_min),
    .clip     (clip),
    .cfg_err  (cfg_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = '0; preload = '0; clip_clr = '0; delta = '0; up_dn = '0;
  endtask

  task automatic load(input logic [3:0] mask, input logic [7:0] v);
    idle();
    preload = mask; pl_data = v;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 4'b1111; up_dn = 4'b1111; delta = 4'd3;
    cyc();
    tests++; if (qout !== 32'h0) begin fails++; $display("FAIL reset_qout got %h exp %h", qout, 32'h0); end
    tests++; if (clip !== 4'b0) begin fails++; $display("FAIL reset_clip got %b exp %b", clip, 4'b0); end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
    tests++; if (at_min !== 4'b0) begin fails++; $display("FAIL reset_at_min got %b exp %b", at_min, 4'b0); end
    reset = 1'b1;
    idle();
  endtask

  task automatic test_preload();
    load(4'b0001, 8'h05);
    tests++; if (qout[7:0] !== 8'h10) begin fails++; $display("FAIL pl_clamp_lo got %h exp %h", qout[7:0], 8'h10); end
    tests++; if (at_min !== 4'b0001) begin fails++; $display("FAIL pl_at_min got %b exp %b", at_min, 4'b0001); end
    load(4'b0001, 8'hFF);
    tests++; if (qout[7:0] !== 8'hF0) begin fails++; $display("FAIL pl_clamp_hi got %h exp %h", qout[7:0], 8'hF0); end
    tests++; if (at_max !== 4'b0001) begin fails++; $display("FAIL pl_at_max got %b exp %b", at_max, 4'b0001); end
    tests++; if (qout[31:8] !== 24'h0) begin fails++; $display("FAIL pl_other_ch got %h exp %h", qout[31:8], 24'h0); end
  endtask

  task automatic test_hold();
    load(4'b0010, 8'hEC);
    mode = 2'd0; en = 4'b0010; up_dn = 4'b0010; delta = 4'd5;
    cyc();
    tests++; if (qout[15:8] !== 8'hEC) begin fails++; $display("FAIL hold_q got %h exp %h", qout[15:8], 8'hEC); end
    tests++; if (clip[1] !== CLIP_ON) begin fails++; $display("FAIL hold_clip got %b exp %b", clip[1], CLIP_ON); end
    delta = 4'd4;
    cyc();
    tests++; if (qout[15:8] !== 8'hF0) begin fails++; $display("FAIL hold_exact_hi got %h exp %h", qout[15:8], 8'hF0); end
    tests++; if (at_max[1] !== 1'b1) begin fails++; $display("FAIL hold_at_max got %b exp 1", at_max[1]); end
    tests++; if (clip[1] !== CLIP_ON) begin fails++; $display("FAIL hold_clip_sticky got %b exp %b", clip[1], CLIP_ON); end
    idle(); clip_clr = 4'b0010;
    cyc();
    tests++; if (clip[1] !== 1'b0) begin fails++; $display("FAIL clip_clr got %b exp 0", clip[1]); end
    idle(); mode = 2'd3; en = 4'b0010; up_dn = 4'b0010; delta = 4'd1;
    cyc();
    tests++; if (qout[15:8] !== 8'hF0) begin fails++; $display("FAIL rsvd_hold got %h exp %h", qout[15:8], 8'hF0); end
    tests++; if (clip[1] !== CLIP_ON) begin fails++; $display("FAIL rsvd_clip got %b exp %b", clip[1], CLIP_ON); end
    idle(); clip_clr = 4'b0010; mode = 2'd0;
    cyc();
    idle();
  endtask

  task automatic test_sat_wrap();
    load(4'b0100, 8'h12);
    mode = 2'd1; en = 4'b0100; up_dn = 4'b0000; delta = 4'd4;
    cyc();
    tests++; if (qout[23:16] !== 8'h10) begin fails++; $display("FAIL sat_dn got %h exp %h", qout[23:16], 8'h10); end
    tests++; if (at_min[2] !== 1'b1) begin fails++; $display("FAIL sat_at_min got %b exp 1", at_min[2]); end
    tests++; if (clip[2] !== CLIP_ON) begin fails++; $display("FAIL sat_clip got %b exp %b", clip[2], CLIP_ON); end
    load(4'b0100, 8'hEE);
    mode = 2'd2; en = 4'b0100; up_dn = 4'b0100; delta = 4'd5;
    cyc();
    tests++; if (qout[23:16] !== 8'h12) begin fails++; $display("FAIL wrap_up got %h exp %h", qout[23:16], 8'h12); end
    up_dn = 4'b0000;
    cyc();
    tests++; if (qout[23:16] !== 8'hEE) begin fails++; $display("FAIL wrap_dn got %h exp %h", qout[23:16], 8'hEE); end
    lo = 8'h10; hi = 8'h12;
    load(4'b0100, 8'h11);
    mode = 2'd2; en = 4'b0100; up_dn = 4'b0100; delta = 4'd5;
    cyc();
    tests++; if (qout[23:16] !== 8'h12) begin fails++; $display("FAIL wrap_big_delta got %h exp %h", qout[23:16], 8'h12); end
    tests++; if (at_max[2] !== 1'b1) begin fails++; $display("FAIL wrap_big_at_max got %b exp 1", at_max[2]); end
    lo = 8'h10; hi = 8'hF0;
    idle(); clip_clr = 4'b0100; mode = 2'd0;
    cyc();
    idle(); en = 4'b0001; up_dn = 4'b0001; delta = 4'd0;
    cyc();
    tests++; if (qout[7:0] !== 8'hF0) begin fails++; $display("FAIL delta0_q got %h exp %h", qout[7:0], 8'hF0); end
    tests++; if (clip[0] !== 1'b0) begin fails++; $display("FAIL delta0_clip got %b exp 0", clip[0]); end
    idle();
  endtask

  task automatic test_simultaneous();
    preload = 4'b1000; pl_data = 8'h50; en = 4'b1000; up_dn = 4'b1000; delta = 4'd3;
    cyc();
    tests++; if (qout[31:24] !== 8'h50) begin fails++; $display("FAIL pl_beats_en got %h exp %h", qout[31:24], 8'h50); end
    load(4'b1000, 8'hEF);
    mode = 2'd0; en = 4'b1000; up_dn = 4'b1000; delta = 4'd5; clip_clr = 4'b1000;
    cyc();
    tests++; if (qout[31:24] !== 8'hEF) begin fails++; $display("FAIL clr_race_q got %h exp %h", qout[31:24], 8'hEF); end
    tests++; if (clip[3] !== CLIP_ON) begin fails++; $display("FAIL set_beats_clr got %b exp %b", clip[3], CLIP_ON); end
    idle(); en = 4'b1111; up_dn = 4'b1111; delta = 4'd1;
    cyc();
    reset = 1'b0;
    cyc();
    tests++; if (qout !== 32'h0) begin fails++; $display("FAIL burst_reset_q got %h exp %h", qout, 32'h0); end
    tests++; if (clip !== 4'b0) begin fails++; $display("FAIL burst_reset_clip got %b exp %b", clip, 4'b0); end
    reset = 1'b1;
    idle();
  endtask

  task automatic test_cfg_err();
    load(4'b1111, 8'h30);
    lo = 8'h80; hi = 8'h40; en = 4'b1111; up_dn = 4'b1111; delta = 4'd2;
    cyc();
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL cfg_err_set got %b exp 1", cfg_err); end
    tests++; if (qout !== 32'h30303030) begin fails++; $display("FAIL cfg_step_ignored got %h exp %h", qout, 32'h30303030); end
    idle(); preload = 4'b0001; pl_data = 8'h60;
    cyc();
    tests++; if (qout !== 32'h30303030) begin fails++; $display("FAIL cfg_pl_ignored got %h exp %h", qout, 32'h30303030); end
    tests++; if (clip !== 4'b0) begin fails++; $display("FAIL cfg_no_clip got %b exp %b", clip, 4'b0); end
    idle(); lo = 8'h10; hi = 8'hF0; en = 4'b1111; up_dn = 4'b1111; delta = 4'd2;
    cyc();
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_err_clr got %b exp 0", cfg_err); end
    tests++; if (qout !== 32'h32323232) begin fails++; $display("FAIL cfg_resume got %h exp %h", qout, 32'h32323232); end
    idle();
  endtask

  task automatic test_multi();
    load(4'b1111, 8'h20);
    en = 4'b1111; up_dn = 4'b0101; delta = 4'd3;
    cyc();
    tests++; if (qout !== 32'h1D231D23) begin fails++; $display("FAIL multi_packed got %h exp %h", qout, 32'h1D231D23); end
    tests++; if (clip !== 4'b0) begin fails++; $display("FAIL multi_clip got %b exp %b", clip, 4'b0); end
    idle();
  endtask

  initial begin
    reset = 1'b0; pl_data = '0; lo = 8'h10; hi = 8'hF0; mode = 2'd0;
    idle();
    test_reset();
    test_preload();
    test_hold();
    test_sat_wrap();
    test_simultaneous();
    test_cfg_err();
    test_multi();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/step_counter_bank.md
Name: step_counter_bank

Overview:
- Bank of N_CH independent bounded up/down step counters sharing one step size, one preload bus and one pair of programmable bounds.
- Generalises the single 8-bit saturating preloadable counter in width, channel count and overflow mode.
- Adds a programmable [lo,hi] window, terminal flags and sticky clip flags.
- Feeds rate/credit tracking logic; all outputs are registered.

Parameters:
- WIDTH, 8, counter width in bits.
- DELTA_W, 4, step-size width in bits; must be <= WIDTH.
- N_CH, 4, number of channels (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  N_CH  per-channel step enable.
- up_dn  in  N_CH  per-channel direction: 1 = up, 0 = down.
- delta  in  DELTA_W  shared step size, unsigned.
- preload  in  N_CH  per-channel preload strobe.
- pl_data  in  WIDTH  shared preload value.
- lo  in  WIDTH  lower bound, inclusive.
- hi  in  WIDTH  upper bound, inclusive.
- mode  in  2  overflow mode; encoding in package.
- clip_clr  in  N_CH  per-channel clear for the sticky clip flag.
- qout  out  N_CH*WIDTH  packed counts; channel i occupies [i*WIDTH +: WIDTH].
- at_max  out  N_CH  registered, qout_i == hi.
- at_min  out  N_CH  registered, qout_i == lo.
- clip  out  N_CH  sticky, a step hit a bound.
- cfg_err  out  1  registered, hi < lo.

Behaviour:
- One clock; reset is synchronous and active-low. Sampled on clk rising edge, wins over everything.
- Reset values: qout=0, clip=0, cfg_err=0. at_max/at_min are recomputed each cycle from the next count against the current lo/hi, so they are registered too.
- Per-channel priority: reset > preload > step (en) > hold.
- Preload:
  - qout_i <= pl_data clamped into [lo,hi]; clip is unaffected.
  - preload with en on the same channel in the same cycle: preload wins and the step is dropped.
- Step arithmetic: done in WIDTH+1 bits, zero-extended delta.
  - Up target t = q + delta.
  - Down target t = q - delta, evaluated as q < lo + delta to avoid underflow.
- In range: up with t <= hi, or down with q >= lo + delta → q <= t.
- Out of range, by mode:
  - MODE_HOLD: q unchanged; clip set.
  - MODE_SAT: q <= hi (up) or lo (down); clip set.
  - MODE_WRAP: span = hi - lo + 1.
    - Up: q <= t - span. Down: q <= q + span - delta.
    - If delta > span, behave as MODE_SAT.
    - clip set.
  - mode = 3 (reserved) behaves as MODE_HOLD.
- delta = 0 with en: count unchanged; no clip.
- clip set has priority over clip_clr in the same cycle.
- Config error:
  - cfg_err registered as (hi < lo).
  - While cfg_err would be 1, steps and preloads are ignored: all counts hold, no clip.
  - Reset still applies.
- Bounds changing mid-operation: counts already outside the new window are not moved until the next preload or step.
  - A step from outside the window evaluates the same rules against the new window. Example: q > hi going up → out of range.
- Latency: one cycle from input to qout/flags. No combinational input-to-output path.

Optional Feature:
- Macro STEP_COUNTER_BANK_CLIP_EN.
- Defined: sticky clip register and clip_clr as above.
- Undefined: no clip storage; clip tied to 0; clip_clr ignored. All count behaviour is identical.

Decomposition:
- Package step_counter_bank_pkg:
  - 2-bit mode typedef: MODE_HOLD=0, MODE_SAT=1, MODE_WRAP=2, MODE_RSVD=3.
  - Helper constant for the reset count (0).
- Sub-module step_counter_lane:
  - One channel's register, next-state/bound logic and clip flag.
  - Instantiated N_CH times by a generate loop.
  - Top level holds shared cfg_err and the packing of qout.

Test Plan:
All with WIDTH=8, DELTA_W=4, N_CH=4, lo=0x10, hi=0xF0.
- Reset and preload: reset low one cycle → all qout=0, clip=0, cfg_err=0. Then preload=4'b0001, pl_data=0x05 → ch0=0x10 (clamped). Then pl_data=0xFF → ch0=0xF0, at_max[0]=1.
- HOLD mode: ch1 at 0xEC, up, delta=5 → stays 0xEC, clip[1]=1. Next cycle delta=4 → 0xF0, at_max[1]=1, clip[1] still 1. clip_clr[1] → clip[1]=0.
- SAT/WRAP mode:
  - SAT, ch2=0x12, down, delta=4 → 0x10, at_min[2]=1, clip[2]=1.
  - WRAP, ch2=0xEE, up, delta=5 → 0xEE+5-0xE1 = 0x12.
  - WRAP, ch2=0x12, down, delta=5 → 0x12+0xE1-5 = 0xEE.
- Simultaneous events: preload and en on ch3 same cycle → preload value wins. Step causing clip while clip_clr=1 → clip stays 1. reset low during a stepping burst → all zero next cycle.
- Config error: lo=0x80, hi=0x40 → cfg_err=1 next cycle. Steps and preloads ignored, counts hold. Restore bounds → cfg_err=0, stepping resumes.
- Multi-channel: en=4'b1111, up_dn=4'b0101, delta=3, all channels at 0x20 → ch0,ch2=0x23 and ch1,ch3=0x1D. Packed qout ordering checked.
